// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: buffered instruction entry, NOP encoding
// and the default reset vector.
package riscv_defines;

  localparam int XLEN_DEF = 32;

  localparam logic [XLEN_DEF-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN_DEF-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO with clear, used for the pending-PC list and the
// instruction queue of the fetch stage.
module fetch_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  input  logic                         clear,
  output T                             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop) && !clear;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order imem requests, wrong-path
// response dropping after redirect, and a registered queue feeding F/D.
module fetch_unit
  import riscv_defines::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            valid_f,
  output logic [XLEN-1:0] instr_f,
  output logic [XLEN-1:0] pc_f
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(3 * DEPTH + 1);

  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pend_head;
  logic [CW-1:0]   pend_cnt;
  logic [CW-1:0]   q_cnt;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     drop_sum;
  logic [SW-1:0]   credits_used;
  logic            pend_full;
  logic            pend_empty;
  logic            q_full;
  logic            q_empty;
  logic            req_fire;
  logic            rsp_keep;
  logic            q_pop;
  fetch_entry_t    q_head;
  fetch_entry_t    q_push_data;

  // Every fetch owns one credit from acceptance until it leaves the queue or is dropped.
  assign credits_used   = SW'(pend_cnt) + SW'(q_cnt) + SW'(drop_cnt);
  assign imem_req_valid = rst_n && !redirect && (credits_used < SW'(DEPTH));
  assign imem_req_addr  = pc_next;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep    = imem_rsp_valid && (drop_cnt == '0) && !redirect;
  assign q_pop       = valid_f && !stall_f && !redirect;
  assign q_push_data = '{pc: pend_head, instr: imem_rsp_data};

  // A response landing in the redirect cycle retires one in-flight fetch either way.
  assign drop_sum = {1'b0, drop_cnt} + {1'b0, pend_cnt} - {{CW{1'b0}}, imem_rsp_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_next  <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect) begin
      pc_next  <= redirect_pc;
      drop_cnt <= drop_sum[CW-1:0];
    end else begin
      if (req_fire) pc_next <= pc_next + XLEN'(4);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  fetch_fifo #(
    .T     (logic [XLEN-1:0]),
    .DEPTH (DEPTH)
  ) u_pend_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (pc_next),
    .pop       (rsp_keep),
    .clear     (redirect),
    .head      (pend_head),
    .full      (pend_full),
    .empty     (pend_empty),
    .count     (pend_cnt)
  );

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_instr_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data (q_push_data),
    .pop       (q_pop),
    .clear     (redirect),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_cnt)
  );

  assign valid_f = !q_empty;
  assign instr_f = valid_f ? q_head.instr : NOP_INSTR;
  assign pc_f    = valid_f ? q_head.pc : '0;

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> ((pend_cnt != '0) || (drop_cnt != '0)));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    credits_used <= SW'(DEPTH));
  a_redirect_align: assert property (@(posedge clk) disable iff (!rst_n)
    redirect |-> (redirect_pc[1:0] == 2'b00));
  a_pend_space: assert property (@(posedge clk) disable iff (!rst_n)
    req_fire |-> (!pend_full || rsp_keep));
  a_pend_known: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep |-> !pend_empty);
  a_queue_space: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep |-> (!q_full || q_pop));

endmodule
